tile_feeder: RTL and testbench

TILE_FEEDER -- requirements
Module: tile_feeder

---
 rtl/tile_feeder_pkg.sv | 42 ++++
 rtl/tile_feeder_if.sv | 27 ++
 rtl/tile_feeder_mem.sv | 36 +++
 rtl/tile_feeder.sv | 127 ++++++++++++
 tb/tb_tile_feeder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/tile_feeder_pkg.sv
// Shared types and constants for the tile feeder: FSM states, matrix geometry,
// raddr field positions, tile address constants and element address helper.
package tile_feeder_pkg;

    localparam int unsigned TILE_DIM   = 4;
    localparam int unsigned MAT_DIM    = 8;
    localparam int unsigned TILE_ELEMS = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned RADDR_W    = 4;
    localparam int unsigned CNT_W      = 5;

    // raddr bit positions
    localparam int unsigned RA_SEL  = 3;
    localparam int unsigned RA_BAD  = 2;
    localparam int unsigned RA_TROW = 1;
    localparam int unsigned RA_TCOL = 0;

    localparam logic [3:0] A1 = 4'h0;
    localparam logic [3:0] A2 = 4'h1;
    localparam logic [3:0] A3 = 4'h2;
    localparam logic [3:0] A4 = 4'h3;
    localparam logic [3:0] B1 = 4'h8;
    localparam logic [3:0] B2 = 4'h9;
    localparam logic [3:0] B3 = 4'hA;
    localparam logic [3:0] B4 = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Element k of a tile, row-major: row = 4*trow + k/4, col = 4*tcol + k%4
    function automatic logic [ADDR_W-1:0] elem_addr(input logic trow, input logic tcol,
                                                    input logic [3:0] k);
        return {trow, k[3:2], tcol, k[1:0]};
    endfunction

endpackage

// File: rtl/tile_feeder_if.sv
// Preload and tile-read bus of the tile feeder.
interface tile_feeder_if;
    import tile_feeder_pkg::*;

    logic                      ld_en;
    logic                      ld_sel;
    logic [ADDR_W-1:0]         ld_addr;
    logic signed [DATA_W-1:0]  ld_data;
    logic                      ren;
    logic [RADDR_W-1:0]        raddr;
    logic signed [DATA_W-1:0]  rdata;
    logic                      rready;
    logic                      busy;
    logic                      tile_done;
    logic                      addr_err;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, ren, raddr,
        input  rdata, rready, busy, tile_done, addr_err
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, ren, raddr,
        output rdata, rready, busy, tile_done, addr_err
    );

endinterface

// File: rtl/tile_feeder_mem.sv
// Matrix A/B storage: one write port, one registered read port (1-cycle latency)
// with read enable and synchronous clear; only the read register is reset.
module tile_feeder_mem
    import tile_feeder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     we,
    input  logic                     wsel,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic                     re,
    input  logic                     clr,
    input  logic                     rsel,
    input  logic [ADDR_W-1:0]        raddr,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] mem_a [2**ADDR_W];
    logic signed [DATA_W-1:0] mem_b [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wsel) mem_b[waddr] <= wdata;
            else      mem_a[waddr] <= wdata;
        end
    end

    // A same-edge write is not visible here: the read samples the old contents
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    rdata <= '0;
        else if (clr) rdata <= '0;
        else if (re)  rdata <= rsel ? mem_b[raddr] : mem_a[raddr];
    end

endmodule

// File: rtl/tile_feeder.sv
// Streams a 4x4 tile of matrix A or B, one element per PULSE/GAP pair.
// Optional TILE_FEEDER_STATS_EN adds an 8-bit completed-tile counter port.
module tile_feeder
    import tile_feeder_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    tile_feeder_if.slave bus
`ifdef TILE_FEEDER_STATS_EN
    ,
    output logic [7:0]   tile_cnt
`endif
);

    state_e             state_q, state_d;
    logic               ren_q;
    logic [RADDR_W-1:0] raddr_q;
    logic [2:0]         tile_q, tile_d;      // {sel, trow, tcol}
    logic [CNT_W-1:0]   cnt_q, cnt_d;        // elements fetched so far
    logic               req, err_d, mem_re, mem_clr;
    logic               rready_q, busy_q, done_q, err_q;

    assign req = bus.ren && (!ren_q || (bus.raddr != raddr_q));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            ren_q    <= 1'b0;
            raddr_q  <= '0;
            tile_q   <= '0;
            cnt_q    <= '0;
            rready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ren_q    <= bus.ren;
            raddr_q  <= bus.raddr;
            tile_q   <= tile_d;
            cnt_q    <= cnt_d;
            rready_q <= (state_d == ST_PULSE);
            busy_q   <= (state_d == ST_LOAD) || (state_d == ST_PULSE) || (state_d == ST_GAP);
            done_q   <= (state_q == ST_GAP) && (state_d == ST_DONE);
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        mem_re  = 1'b0;
        mem_clr = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    if (bus.raddr[RA_BAD]) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                        tile_d  = {bus.raddr[RA_SEL], bus.raddr[RA_TROW], bus.raddr[RA_TCOL]};
                        cnt_d   = '0;
                    end
                end else if (!bus.ren) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD, ST_PULSE, ST_GAP: begin
                if (!bus.ren) begin
                    state_d = ST_IDLE;
                end else if (req) begin
                    if (bus.raddr[RA_BAD]) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                        tile_d  = {bus.raddr[RA_SEL], bus.raddr[RA_TROW], bus.raddr[RA_TCOL]};
                        cnt_d   = '0;
                    end
                end else if (state_q == ST_LOAD) begin
                    state_d = ST_PULSE;
                end else if (state_q == ST_PULSE) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = (cnt_q == CNT_W'(TILE_ELEMS)) ? ST_DONE : ST_PULSE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Each entry into PULSE fetches the next element into the read register
        if (state_d == ST_PULSE) begin
            mem_re = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
        end
        if (state_d == ST_IDLE) mem_clr = 1'b1;
    end

    tile_feeder_mem u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (bus.ld_en),
        .wsel  (bus.ld_sel),
        .waddr (bus.ld_addr),
        .wdata (bus.ld_data),
        .re    (mem_re),
        .clr   (mem_clr),
        .rsel  (tile_q[2]),
        .raddr (elem_addr(tile_q[1], tile_q[0], cnt_q[3:0])),
        .rdata (bus.rdata)
    );

    assign bus.rready    = rready_q;
    assign bus.busy      = busy_q;
    assign bus.tile_done = done_q;
    assign bus.addr_err  = err_q;

`ifdef TILE_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                            tile_cnt <= '0;
        else if ((state_q == ST_GAP) && (state_d == ST_DONE)) tile_cnt <= tile_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_tile_feeder.sv
// Self-checking bench for tile_feeder: directed scenarios plus randomized tiles
// checked against a matrix-level reference model.
module tb_tile_feeder;
    import tile_feeder_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    tile_feeder_if bus ();
`ifdef TILE_FEEDER_STATS_EN
    logic [7:0] tile_cnt;
    int         exp_cnt;
`endif

    tile_feeder dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef TILE_FEEDER_STATS_EN
        ,
        .tile_cnt (tile_cnt)
`endif
    );

    logic [15:0] ma [8][8];
    logic [15:0] mb [8][8];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int elem_r(input logic [3:0] t, input int k);
        return 4 * int'(t[1]) + k / 4;
    endfunction

    function automatic int elem_c(input logic [3:0] t, input int k);
        return 4 * int'(t[0]) + k % 4;
    endfunction

    function automatic logic [15:0] exp_elem(input logic [3:0] t, input int k);
        return t[3] ? mb[elem_r(t, k)][elem_c(t, k)] : ma[elem_r(t, k)][elem_c(t, k)];
    endfunction

    // Drive a write to element k of tile t and update the model
    task automatic drive_wr(input logic [3:0] t, input int k, input logic [15:0] v);
        bus.ld_en   = 1'b1;
        bus.ld_sel  = t[3];
        bus.ld_addr = 6'(elem_r(t, k) * 8 + elem_c(t, k));
        bus.ld_data = v;
        if (t[3]) mb[elem_r(t, k)][elem_c(t, k)] = v;
        else      ma[elem_r(t, k)][elem_c(t, k)] = v;
    endtask

    task automatic load(input logic sel, input int r, input int c, input logic [15:0] v);
        bus.ld_en   = 1'b1;
        bus.ld_sel  = sel;
        bus.ld_addr = 6'(r * 8 + c);
        bus.ld_data = v;
        if (sel) mb[r][c] = v;
        else     ma[r][c] = v;
        step;
        bus.ld_en = 1'b0;
    endtask

    task automatic idle_cycle;
        bus.ren = 1'b0;
        step;
        chk("idle_busy", 16'(bus.busy), 16'd0);
        chk("idle_rdata", bus.rdata, 16'd0);
    endtask

    // Request tile t and check the first nk elements; wr_k >= 0 exercises
    // same-edge write (old value) and write-ahead (new value) at element wr_k
    task automatic stream(input logic [3:0] t, input int nk, input int wr_k);
        logic [15:0] e;
        bus.ren   = 1'b1;
        bus.raddr = t;
        step;
        chk("load_busy", 16'(bus.busy), 16'd1);
        chk("load_rready", 16'(bus.rready), 16'd0);
        for (int k = 0; k < nk; k++) begin
            e = exp_elem(t, k);
            if (k == wr_k) drive_wr(t, k, ~e);
            step;
            bus.ld_en = 1'b0;
            chk($sformatf("pulse_rready_%0d", k), 16'(bus.rready), 16'd1);
            chk($sformatf("pulse_rdata_%0d", k), bus.rdata, e);
            chk($sformatf("pulse_busy_%0d", k), 16'(bus.busy), 16'd1);
            if (k == wr_k && k < 15) drive_wr(t, k + 1, 16'h5A00 + 16'(k));
            step;
            bus.ld_en = 1'b0;
            chk($sformatf("gap_rready_%0d", k), 16'(bus.rready), 16'd0);
            chk($sformatf("gap_rdata_%0d", k), bus.rdata, e);
            chk($sformatf("gap_done_%0d", k), 16'(bus.tile_done), 16'd0);
        end
    endtask

    task automatic full_tile(input logic [3:0] t, input int wr_k);
        stream(t, 16, wr_k);
        step;
        chk("done_pulse", 16'(bus.tile_done), 16'd1);
        chk("done_busy", 16'(bus.busy), 16'd0);
        chk("done_rready", 16'(bus.rready), 16'd0);
`ifdef TILE_FEEDER_STATS_EN
        exp_cnt = (exp_cnt + 1) % 256;
        chk("tile_cnt", 16'(tile_cnt), 16'(exp_cnt));
`endif
        step;
        chk("done_once", 16'(bus.tile_done), 16'd0);
        chk("done_hold_rready", 16'(bus.rready), 16'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rready"}, 16'(bus.rready), 16'd0);
        chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_done"}, 16'(bus.tile_done), 16'd0);
        chk({tag, "_err"}, 16'(bus.addr_err), 16'd0);
        chk({tag, "_rdata"}, bus.rdata, 16'd0);
`ifdef TILE_FEEDER_STATS_EN
        chk({tag, "_cnt"}, 16'(tile_cnt), 16'd0);
`endif
    endtask

    initial begin
        logic [3:0] tiles [8];
        tiles = '{A1, A2, A3, A4, B1, B2, B3, B4};
`ifdef TILE_FEEDER_STATS_EN
        exp_cnt = 0;
`endif
        rstn        = 1'b0;
        bus.ld_en   = 1'b0;
        bus.ld_sel  = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.ren     = 1'b0;
        bus.raddr   = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                load(1'b0, r, c, 16'(8 * r + c));
                load(1'b1, r, c, 16'(-(8 * r + c)));
            end

        // Tile A1, then switch to B1 with ren held high
        full_tile(A1, -1);
        full_tile(B1, -1);
        idle_cycle;
        full_tile(B4, -1);

        // Abort after element 5, then restart from element 0
        idle_cycle;
        stream(A2, 6, -1);
        bus.ren = 1'b0;
        step;
        chk("abort_rready", 16'(bus.rready), 16'd0);
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_rdata", bus.rdata, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("abort_quiet_rready", 16'(bus.rready), 16'd0);
            chk("abort_no_done", 16'(bus.tile_done), 16'd0);
        end
        full_tile(A2, -1);

        // Invalid tile address
        idle_cycle;
        bus.ren   = 1'b1;
        bus.raddr = 4'h4;
        step;
        chk("err_pulse", 16'(bus.addr_err), 16'd1);
        chk("err_busy", 16'(bus.busy), 16'd0);
        chk("err_rready", 16'(bus.rready), 16'd0);
        for (int i = 0; i < 4; i++) begin
            step;
            chk("err_once", 16'(bus.addr_err), 16'd0);
            chk("err_no_rready", 16'(bus.rready), 16'd0);
            chk("err_idle_busy", 16'(bus.busy), 16'd0);
        end

        // Mid-stream raddr change restarts on the new tile
        stream(A3, 3, -1);
        full_tile(B3, -1);

        // Same-edge write returns old data, earlier write is seen
        idle_cycle;
        full_tile(A4, 6);

        // Randomized contents and tile order
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                load(1'b0, r, c, 16'($urandom));
                load(1'b1, r, c, 16'($urandom));
            end
        for (int i = 0; i < 8; i++) begin
            idle_cycle;
            full_tile(tiles[$urandom_range(7)], ($urandom_range(3) == 0) ? int'($urandom_range(14)) : -1);
        end

        // Reset during element 9
        idle_cycle;
        stream(B2, 9, -1);
        step;
        chk("pre_reset_rready", 16'(bus.rready), 16'd1);
        chk("pre_reset_rdata", bus.rdata, exp_elem(B2, 9));
        rstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
`ifdef TILE_FEEDER_STATS_EN
        exp_cnt = 0;
`endif
        full_tile(B2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
